// File: rtl/sample_accum_pkg.sv
// Shared constants and the width-generic clipping adder used by sample_accum.
package sample_accum_pkg;

   localparam int unsigned ADD_W = 64;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : int'($clog2(n));
   endfunction

   // Returns {overflow, sum}; the sum is clipped to w bits by saturation or wrap.
   function automatic logic [ADD_W:0] sat_add(input logic [ADD_W-1:0] a,
                                              input logic [ADD_W-1:0] b,
                                              input int unsigned      w,
                                              input logic             sat);
      logic [ADD_W:0] sum;
      logic [ADD_W:0] lim;
      logic           ovf;
      sum = {1'b0, a} + {1'b0, b};
      lim = ({{ADD_W{1'b0}}, 1'b1} << w) - {{ADD_W{1'b0}}, 1'b1};
      ovf = (sum > lim);
      if (ovf && sat) sum = lim;
      else            sum = sum & lim;
      return {ovf, sum[ADD_W-1:0]};
   endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational acc + zero-extended sample, DSIZE result plus overflow flag (DSIZE < 64).
// Saturates at all-ones when SAMPLE_ACCUM_SAT_EN is defined, otherwise wraps.
module sat_adder
   import sample_accum_pkg::*;
#(
   parameter int ISIZE = 8,
   parameter int DSIZE = 16
) (
   input  logic [DSIZE-1:0] acc_i,
   input  logic [ISIZE-1:0] sample_i,
   output logic [DSIZE-1:0] sum_o,
   output logic             ovf_o
);

`ifdef SAMPLE_ACCUM_SAT_EN
   localparam logic SAT = 1'b1;
`else
   localparam logic SAT = 1'b0;
`endif

   logic [ADD_W:0]         res;
   logic [ADD_W-DSIZE-1:0] unused_hi;

   assign res = sat_add(ADD_W'(acc_i), ADD_W'(sample_i), DSIZE, SAT);
   assign {ovf_o, unused_hi, sum_o} = res;

endmodule

// File: rtl/sample_accum.sv
// Sums NSAMPLE unsigned samples per window into a held output register; sum valid 1 cycle after final accept.
// Input stalls only when the final sample would overwrite an unconsumed sum. Optional SAMPLE_ACCUM_SAT_EN adds saturation + ovf.
module sample_accum
   import sample_accum_pkg::*;
#(
   parameter int ISIZE   = 8,
   parameter int DSIZE   = 16,
   parameter int NSAMPLE = 16
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ISIZE-1:0] indata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DSIZE-1:0] outdata
`ifdef SAMPLE_ACCUM_SAT_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned    CW   = cnt_width(NSAMPLE);
   localparam logic [CW-1:0]  LAST = CW'(NSAMPLE - 1);

   logic [DSIZE-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovld_q, ovld_d;
   logic [DSIZE-1:0] odat_q, odat_d;
   logic [DSIZE-1:0] sum;
   logic             accept;
   logic             last;

   assign last      = (cnt_q == LAST);
   assign in_ready  = !clear && !(ovld_q && !out_ready && last);
   assign accept    = in_valid && in_ready;
   assign out_valid = ovld_q;
   assign outdata   = odat_q;

`ifdef SAMPLE_ACCUM_SAT_EN
   logic add_ovf;
   logic win_ovf_q, win_ovf_d;
   logic ovf_q, ovf_d;
`else
   logic unused_add_ovf;
`endif

   sat_adder #(.ISIZE(ISIZE), .DSIZE(DSIZE)) u_add (
      .acc_i    (acc_q),
      .sample_i (indata),
      .sum_o    (sum),
`ifdef SAMPLE_ACCUM_SAT_EN
      .ovf_o    (add_ovf)
`else
      .ovf_o    (unused_add_ovf)
`endif
   );

   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      ovld_d = ovld_q && !out_ready;
      odat_d = odat_q;
      if (clear) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         if (last) begin
            odat_d = sum;
            ovld_d = 1'b1;
            acc_d  = '0;
            cnt_d  = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         ovld_q <= 1'b0;
         odat_q <= '0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         ovld_q <= ovld_d;
         odat_q <= odat_d;
      end
   end

`ifdef SAMPLE_ACCUM_SAT_EN
   // ovf is sticky across the window and published alongside the sum.
   always_comb begin
      win_ovf_d = win_ovf_q;
      ovf_d     = ovf_q;
      if (clear) begin
         win_ovf_d = 1'b0;
      end else if (accept) begin
         if (last) begin
            ovf_d     = win_ovf_q | add_ovf;
            win_ovf_d = 1'b0;
         end else begin
            win_ovf_d = win_ovf_q | add_ovf;
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         win_ovf_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         win_ovf_q <= win_ovf_d;
         ovf_q     <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sample_accum.sv
// Directed checks of sample_accum (NSAMPLE=4) plus a DSIZE=9 instance for the overflow window.
module tb_sample_accum;

   logic        clock;
   logic        rst;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  indata;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] outdata;

   logic        v9;
   logic        rdy9;
   logic [7:0]  d9;
   logic        ov9;
   logic [8:0]  od9;
`ifdef SAMPLE_ACCUM_SAT_EN
   logic        ovf;
   logic        ovf9;
`endif

   int checks;
   int failures;

   sample_accum #(.ISIZE(8), .DSIZE(16), .NSAMPLE(4)) u_dut (
      .clock     (clock),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .indata    (indata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .outdata   (outdata)
`ifdef SAMPLE_ACCUM_SAT_EN
      ,
      .ovf       (ovf)
`endif
   );

   sample_accum #(.ISIZE(8), .DSIZE(9), .NSAMPLE(4)) u_dut9 (
      .clock     (clock),
      .rst       (rst),
      .clear     (1'b0),
      .in_valid  (v9),
      .in_ready  (rdy9),
      .indata    (d9),
      .out_valid (ov9),
      .out_ready (1'b1),
      .outdata   (od9)
`ifdef SAMPLE_ACCUM_SAT_EN
      ,
      .ovf       (ovf9)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        vld;
      logic [7:0]  dat;
      logic        ordy;
      logic        clr;
      logic        exp_rdy;
      logic        exp_ovld;
      logic [15:0] exp_odat;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] d, input logic o, input logic c,
                      input logic er, input logic eov, input logic [15:0] eod);
      vec_t t;
      t.vld = v; t.dat = d; t.ordy = o; t.clr = c;
      t.exp_rdy = er; t.exp_ovld = eov; t.exp_odat = eod;
      tv.push_back(t);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic o, input logic c);
      in_valid = v; indata = d; out_ready = o; clear = c;
      @(posedge clock);
      #1;
   endtask

   initial begin
      int nobs;
      logic [8:0] exp9;
      checks = 0; failures = 0;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; indata = '0; out_ready = 1'b0;
      v9 = 1'b0; d9 = '0;

      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_outdata", {16'd0, outdata}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clock);
      #1;

      // basic window, out_ready high
      add(1, 8'd1, 1, 0, 1, 0, 16'd0);
      add(1, 8'd2, 1, 0, 1, 0, 16'd0);
      add(1, 8'd3, 1, 0, 1, 0, 16'd0);
      add(1, 8'd4, 1, 0, 1, 1, 16'd10);
      add(0, 8'd0, 1, 0, 1, 0, 16'd10);
      // partial window discarded by clear
      add(1, 8'd7, 1, 0, 1, 0, 16'd10);
      add(1, 8'd7, 1, 0, 1, 0, 16'd10);
      add(0, 8'd0, 1, 1, 0, 0, 16'd10);
      add(1, 8'd9, 1, 1, 0, 0, 16'd10);
      add(1, 8'd1, 1, 0, 1, 0, 16'd10);
      add(1, 8'd1, 1, 0, 1, 0, 16'd10);
      add(1, 8'd1, 1, 0, 1, 0, 16'd10);
      add(1, 8'd1, 1, 0, 1, 1, 16'd4);
      add(0, 8'd0, 1, 0, 1, 0, 16'd4);
      // held sum with out_ready low, then back-to-back release
      add(1, 8'd1, 0, 0, 1, 0, 16'd4);
      add(1, 8'd2, 0, 0, 1, 0, 16'd4);
      add(1, 8'd3, 0, 0, 1, 0, 16'd4);
      add(1, 8'd4, 0, 0, 1, 1, 16'd10);
      add(1, 8'd5, 0, 0, 1, 1, 16'd10);
      add(1, 8'd6, 0, 0, 1, 1, 16'd10);
      add(1, 8'd7, 0, 0, 1, 1, 16'd10);
      add(1, 8'd8, 0, 0, 0, 1, 16'd10);
      add(1, 8'd8, 1, 0, 1, 1, 16'd26);
      add(0, 8'd0, 1, 0, 1, 0, 16'd26);

      foreach (tv[i]) begin
         in_valid = tv[i].vld; indata = tv[i].dat; out_ready = tv[i].ordy; clear = tv[i].clr;
         #1;
         chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].exp_rdy});
         @(posedge clock);
         #1;
         chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].exp_ovld});
         chk($sformatf("v%0d_outdata", i), {16'd0, outdata}, {16'd0, tv[i].exp_odat});
      end

      // async reset while a sum is held and the next window is at cnt=2
      drive(1, 8'd1, 0, 0);
      drive(1, 8'd2, 0, 0);
      drive(1, 8'd3, 0, 0);
      drive(1, 8'd4, 0, 0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_outdata", {16'd0, outdata}, 32'd10);
      drive(1, 8'd1, 0, 0);
      drive(1, 8'd1, 0, 0);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_outdata", {16'd0, outdata}, 32'd0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      drive(1, 8'd2, 1, 0);
      drive(1, 8'd3, 1, 0);
      drive(1, 8'd4, 1, 0);
      drive(1, 8'd5, 1, 0);
      chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
      chk("post_rst_outdata", {16'd0, outdata}, 32'd14);
      drive(0, 8'd0, 1, 0);
      chk("post_rst_drop", {31'd0, out_valid}, 32'd0);

      // 40 back-to-back samples, data i+1
      nobs = 0;
      for (int i = 0; i < 40; i++) begin
         in_valid = 1'b1; indata = 8'(i + 1); out_ready = 1'b1; clear = 1'b0;
         #1;
         chk($sformatf("s%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
         @(posedge clock);
         #1;
         chk($sformatf("s%0d_out_valid", i), {31'd0, out_valid}, (i % 4 == 3) ? 32'd1 : 32'd0);
         if (out_valid) nobs++;
         if (i % 4 == 3)
            chk($sformatf("s%0d_outdata", i), {16'd0, outdata}, 32'(16 * (i / 4) + 10));
      end
      in_valid = 1'b0;
      chk("stream_sum_count", 32'(nobs), 32'd10);

      // DSIZE=9 overflow window, then a small window
`ifdef SAMPLE_ACCUM_SAT_EN
      exp9 = 9'd511;
`else
      exp9 = 9'd508;
`endif
      for (int i = 0; i < 8; i++) begin
         v9 = 1'b1; d9 = (i < 4) ? 8'd255 : 8'd1;
         #1;
         chk($sformatf("d9_%0d_in_ready", i), {31'd0, rdy9}, 32'd1);
         @(posedge clock);
         #1;
      end
      v9 = 1'b0;
      chk("d9_small_out_valid", {31'd0, ov9}, 32'd1);
      chk("d9_small_outdata", {23'd0, od9}, 32'd4);
`ifdef SAMPLE_ACCUM_SAT_EN
      chk("d9_small_ovf", {31'd0, ovf9}, 32'd0);
`endif
      // rerun the big window alone to observe its sum
      for (int i = 0; i < 4; i++) begin
         v9 = 1'b1; d9 = 8'd255;
         @(posedge clock);
         #1;
      end
      v9 = 1'b0;
      chk("d9_big_out_valid", {31'd0, ov9}, 32'd1);
      chk("d9_big_outdata", {23'd0, od9}, {23'd0, exp9});
`ifdef SAMPLE_ACCUM_SAT_EN
      chk("d9_big_ovf", {31'd0, ovf9}, 32'd1);
      chk("d16_ovf_clear", {31'd0, ovf}, 32'd0);
`endif
      @(posedge clock);
      #1;
      chk("d9_drop", {31'd0, ov9}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sample_accum.md
SAMPLE_ACCUM -- requirements
Module: sample_accum

Interface
REQ-001 SHALL have parameter ISIZE, default 8: input sample width, unsigned.
REQ-002 SHALL have parameter DSIZE, default 16: accumulated sum width, feeding the downstream ceiling stage; ISIZE <= DSIZE.
REQ-003 SHALL have parameter NSAMPLE, default 16: samples per window, >= 2.
REQ-004 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous discard of the partial window.
REQ-007 SHALL have port in_valid  input  1  sample valid.
REQ-008 SHALL have port in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-009 SHALL have port indata  input  ISIZE  sample.
REQ-010 SHALL have port out_valid  output  1  window sum valid.
REQ-011 SHALL have port out_ready  input  1  sum consumed when out_valid && out_ready.
REQ-012 SHALL have port outdata  output  DSIZE  registered window sum.

Function
REQ-013 SHALL keep an accumulator acc (DSIZE) and a sample counter cnt (0..NSAMPLE-1), plus a separate output register, so the next window accumulates while a sum is held.
REQ-014 SHALL, on a non-final accept (cnt < NSAMPLE-1), set acc <= acc + indata and cnt <= cnt+1.
REQ-015 SHALL, on the final accept (cnt == NSAMPLE-1), load outdata with acc + indata, set out_valid, and set acc <= 0, cnt <= 0.
REQ-016 SHALL assert out_valid in the cycle after the final accept (latency 1).
REQ-017 SHALL hold outdata and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL drive in_ready = !clear && !(out_valid && !out_ready && cnt == NSAMPLE-1), with a combinational path from out_ready.
REQ-019 SHALL, when the final accept coincides with out_valid && out_ready, load the new sum and keep out_valid at 1 with no bubble.
REQ-020 SHALL, on an output handshake with no final accept, clear out_valid next cycle; outdata keeps its last value.
REQ-021 SHALL, on clear, set acc <= 0 and cnt <= 0, accept no sample that cycle, and leave out_valid/outdata untouched.
REQ-022 SHALL treat indata as unsigned and zero-extend it to DSIZE before the add.

Reset
REQ-023 SHALL, on rst, asynchronously force acc=0, cnt=0, out_valid=0, outdata=0; in_ready evaluates to 1 while rst is released and clear is low.
REQ-024 SHALL, on rst asserted mid-window or mid-hold, discard both the partial sum and the held sum.

Configuration
REQ-025 SHALL honour macro SAMPLE_ACCUM_SAT_EN: when defined, the add saturates at all-ones, and an extra output ovf (1 bit) is registered with outdata. ovf is 1 when any add in that window saturated; reset value 0.
REQ-026 SHALL, without SAMPLE_ACCUM_SAT_EN, wrap the add modulo 2^DSIZE and omit the ovf port.

Structure
REQ-027 SHALL place the counter-width constant (clog2 of NSAMPLE) and the saturating-add helper in package sample_accum_pkg.
REQ-028 SHALL implement the add as sub-module sat_adder (ISIZE+DSIZE in, DSIZE out plus overflow flag), saturating or wrapping per REQ-025/026.

Verification (ISIZE=8, DSIZE=16, NSAMPLE=4 unless stated)
REQ-029 SHALL cover: samples 1,2,3,4 with out_ready=1 -> out_valid 1 cycle after 4th accept, outdata=10, then out_valid drops.
REQ-030 SHALL cover: the window 1,2,3,4 followed by 5,6,7, with out_ready=0 -> outdata held at 10; in_ready drops when cnt==3. Then out_ready=1 -> 4th sample accepted and outdata=5+6+7+x with no bubble.
REQ-031 SHALL cover: DSIZE=9, four samples of 255 -> with the macro outdata=511 and ovf=1; without the macro outdata=508.
REQ-032 SHALL cover: 2 samples accepted, then clear, then 1,1,1,1 -> outdata=4; in_ready=0 during the clear cycle.
REQ-033 SHALL cover: rst pulsed while out_valid=1 and cnt=2 -> out_valid=0, outdata=0, cnt=0 immediately; the next 4 samples produce the correct sum.
REQ-034 SHALL cover: continuous in_valid with out_ready=1 for 40 samples -> 10 sums, out_valid asserted every 4th cycle, no sample lost.
